lb_bank_sched: RTL

Bank scheduler for the line-buffer RAM array in the video pipeline. It rotates NBANK single-port line RAMs, so that one bank captures the incoming active line while the other NBANK-1 banks are read in parallel, giving a vertical pixel window. It generates per-bank chip-select, write-enable and a shared column address from the sync/DE stream. It also shares idle RAM cycles with a host readback port through a fixed-priority arbiter.

---
 rtl/lb_bank_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lb_bank_sched.sv
// Line-buffer bank scheduler: rotates NBANK line RAMs between capture and window read,
// with an optional host readback arbiter compiled in by LB_SCHED_HOST_EN.
module lb_bank_sched #(
  parameter int unsigned HACT       = 10,
  parameter int unsigned NBANK      = 3,
  localparam int unsigned ADDR_WIDTH = $clog2(HACT)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_vsync,
  input  logic                  i_de,
  input  logic                  i_hreq,
  input  logic [1:0]            i_hbank,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  output logic [NBANK-1:0]      o_bank_cs,
  output logic [NBANK-1:0]      o_bank_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [1:0]            o_wr_bank,
  output logic                  o_rd_valid,
  output logic [10:0]           o_line_cnt,
  output logic                  o_frame_start,
  output logic                  o_ovf,
  output logic                  o_hgnt,
  output logic                  o_hvalid
);

  // Column counter is one bit wider when needed so it can hold HACT itself (overflow marker).
  localparam int unsigned ColWidth = $clog2(HACT + 1);

  localparam logic [ColWidth-1:0] HactCol  = ColWidth'(HACT);
  localparam logic [1:0]          LastBank = 2'(NBANK - 1);
  localparam logic [1:0]          FillDone = 2'(NBANK - 2);
  localparam logic [10:0]         LineMax  = 11'h7ff;

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e              state_q, state_d;
  logic [ColWidth-1:0] col_q, col_d;
  logic [1:0]          wr_bank_q, wr_bank_d;
  logic [1:0]          fill_q, fill_d;
  logic [10:0]         line_cnt_q, line_cnt_d;
  logic                ovf_q, ovf_d;
  logic                de_q, de_d;
  logic                vsync_q, vsync_d;
  logic                frame_start_q, frame_start_d;
  logic                hvalid_q, hvalid_d;
  logic                rst_done_q, rst_done_d;

  logic line_end;
  logic ovf_cyc;
  logic wr_en;
  logic rd_en;
  logic hgnt;

  assign line_end = de_q & ~i_de;
  assign ovf_cyc  = (col_q == HactCol);
  assign wr_en    = (state_q != StIdle) & i_de & ~ovf_cyc;
  assign rd_en    = (state_q == StRun) & i_de;

`ifdef LB_SCHED_HOST_EN
  // Pixel traffic always wins; host only gets cycles with DE low.
  assign hgnt = i_hreq & ~i_de & rst_done_q;
`else
  logic unused_host;
  assign unused_host = ^{i_hreq, i_hbank, i_haddr, rst_done_q};
  assign hgnt        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    wr_bank_d     = wr_bank_q;
    fill_d        = fill_q;
    line_cnt_d    = line_cnt_q;
    ovf_d         = ovf_q;
    de_d          = i_de;
    vsync_d       = i_vsync;
    frame_start_d = vsync_q & ~i_vsync;
    hvalid_d      = hgnt;
    rst_done_d    = 1'b1;

    if (i_vsync) begin
      // Vsync clear takes precedence over a coincident line end.
      state_d    = StIdle;
      col_d      = '0;
      wr_bank_d  = '0;
      fill_d     = '0;
      line_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (state_q == StIdle) begin
        state_d = StFill;
      end
      if (i_de) begin
        if (col_q < HactCol) begin
          col_d = col_q + ColWidth'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (line_end) begin
        col_d     = '0;
        wr_bank_d = (wr_bank_q == LastBank) ? 2'd0 : wr_bank_q + 2'd1;
        if (line_cnt_q != LineMax) begin
          line_cnt_d = line_cnt_q + 11'd1;
        end
        if (state_q == StFill) begin
          fill_d = fill_q + 2'd1;
          if (fill_q == FillDone) begin
            state_d = StRun;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      col_q         <= '0;
      wr_bank_q     <= '0;
      fill_q        <= '0;
      line_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      de_q          <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      hvalid_q      <= 1'b0;
      rst_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      wr_bank_q     <= wr_bank_d;
      fill_q        <= fill_d;
      line_cnt_q    <= line_cnt_d;
      ovf_q         <= ovf_d;
      de_q          <= de_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      hvalid_q      <= hvalid_d;
      rst_done_q    <= rst_done_d;
    end
  end

  // RAM controls are combinational so the banks sample them on the same edge.
  always_comb begin
    o_bank_cs = '0;
    o_bank_we = '0;
    for (int b = 0; b < int'(NBANK); b++) begin
      o_bank_we[b] = wr_en & (wr_bank_q == 2'(b));
      o_bank_cs[b] = (wr_en & (wr_bank_q == 2'(b))) |
                     (rd_en & (wr_bank_q != 2'(b))) |
                     (hgnt  & (i_hbank == 2'(b)));
    end
    o_addr = hgnt ? i_haddr : col_q[ADDR_WIDTH-1:0];
  end

  assign o_wr_bank     = wr_bank_q;
  assign o_rd_valid    = rd_en;
  assign o_line_cnt    = line_cnt_q;
  assign o_frame_start = frame_start_q;
  assign o_ovf         = ovf_q;
  assign o_hgnt        = hgnt;
  assign o_hvalid      = hvalid_q;

endmodule
